// File: rtl/accel_spi_reader.sv
// SPI master for the board accelerometer: writes POWER_CTL once, then reads X/Y on every update tick
// and presents them as 9-bit offset-binary tilt. Define ACCEL_AVG_EN for a 4-sample moving average per axis.

module accel_spi_axis (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] sample,
  output logic [8:0] tilt
);
`ifdef ACCEL_AVG_EN
  // Three stored samples plus the incoming one form the 4-entry window.
  logic [2:0][7:0]   hist;
  logic signed [9:0] sum;
  logic [7:0]        avg;

  always_comb begin
    sum = 10'($signed(sample)) + 10'($signed(hist[0])) +
          10'($signed(hist[1])) + 10'($signed(hist[2]));
    avg = 8'(sum >>> 2);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist <= '0;
      tilt <= 9'd256;
    end else if (load) begin
      hist <= {hist[1:0], sample};
      tilt <= {~avg[7], avg[6:0], 1'b0};
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset)    tilt <= 9'd256;
    else if (load) tilt <= {~sample[7], sample[6:0], 1'b0};
  end
`endif
endmodule

module accel_spi_reader #(
  parameter int CLK_FREQUENCY_HZ       = 100000000,
  parameter int SCLK_FREQUENCY_HZ      = 1000000,
  parameter int UPDATE_FREQUENCY_HZ    = 100,
  parameter int POWERUP_DELAY_CYCLES   = 1000000,
  parameter int CNTR_WIDTH             = 32,
  parameter int SIMULATE               = 0,
  parameter int SIMULATE_FREQUENCY_CNT = 50
) (
  input  logic       clk,
  input  logic       reset,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n,
  output logic [8:0] accelX_OUT,
  output logic [8:0] accelY_OUT,
  output logic       data_valid,
  output logic       init_done
);
  localparam int NUM_AXES = 2;
  localparam int HP       = (SIMULATE != 0) ? 2 : CLK_FREQUENCY_HZ / (2 * SCLK_FREQUENCY_HZ);
  localparam int PERIOD   = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT : CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ;
  localparam int PWR_DLY  = (SIMULATE != 0) ? 10 : POWERUP_DELAY_CYCLES;

  localparam logic [CNTR_WIDTH-1:0] HP_END   = CNTR_WIDTH'(HP - 1);
  localparam logic [CNTR_WIDTH-1:0] GAP_END  = CNTR_WIDTH'(2 * HP - 1);
  localparam logic [CNTR_WIDTH-1:0] PWR_END  = CNTR_WIDTH'(PWR_DLY - 1);
  localparam logic [CNTR_WIDTH-1:0] TICK_END = CNTR_WIDTH'(PERIOD - 1);

  // Commands left-justified; CFG only uses the top 24 bits.
  localparam logic [31:0] CFG_CMD = 32'h0A2D_0200;
  localparam logic [31:0] RD_CMD  = 32'h0B08_0000;

  typedef enum logic [2:0] {S_INIT_WAIT, S_CFG, S_IDLE, S_RD, S_UPD, S_GAP} state_t;

  state_t                  state, state_nxt;
  logic [CNTR_WIDTH-1:0]   cnt, tick_cnt;
  logic [6:0]              edge_idx, last_edge;
  logic [30:0]             tx_sr;
  logic [15:0]             rx_sr;
  logic                    pending, tick;
  logic                    in_xfer, hp_done, xfer_done, sclk_rise, sclk_fall, start;
  logic [31:0]             cmd;
  logic [NUM_AXES-1:0][7:0] samples;
  logic [NUM_AXES-1:0][8:0] tilts;

  assign tick = (tick_cnt == TICK_END);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_INIT_WAIT;
    else        state <= state_nxt;
  end

  // Transfer events: edge_idx even -> sclk rises next, odd -> falls; the event after
  // the last fall releases CS.
  always_comb begin
    state_nxt = state;
    in_xfer   = (state == S_CFG) || (state == S_RD);
    last_edge = (state == S_CFG) ? 7'd48 : 7'd64;
    hp_done   = (cnt == HP_END);
    xfer_done = in_xfer && hp_done && (edge_idx == last_edge);
    sclk_rise = in_xfer && hp_done && !edge_idx[0] && (edge_idx != last_edge);
    sclk_fall = in_xfer && hp_done && edge_idx[0];
    case (state)
      S_INIT_WAIT: if (cnt == PWR_END)   state_nxt = S_CFG;
      S_CFG:       if (xfer_done)        state_nxt = S_GAP;
      S_IDLE:      if (tick || pending)  state_nxt = S_RD;
      S_RD:        if (xfer_done)        state_nxt = S_UPD;
      S_UPD:                             state_nxt = S_GAP;
      S_GAP:       if (cnt == GAP_END)   state_nxt = S_IDLE;
      default:                           state_nxt = S_INIT_WAIT;
    endcase
    start = ((state == S_INIT_WAIT) && (state_nxt == S_CFG)) ||
            ((state == S_IDLE) && (state_nxt == S_RD));
    cmd   = (state == S_IDLE) ? RD_CMD : CFG_CMD;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      tick_cnt   <= '0;
      pending    <= 1'b0;
      edge_idx   <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      spi_sclk   <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_mosi   <= 1'b0;
      data_valid <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      cnt      <= ((state_nxt != state) || (in_xfer && hp_done)) ? '0 : cnt + 1'b1;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      // Any pending request is consumed by the IDLE->RD move; extra ticks fold into one.
      if (state == S_IDLE) pending <= 1'b0;
      else if (tick)       pending <= 1'b1;

      if (start) begin
        edge_idx <= '0;
        spi_cs_n <= 1'b0;
        spi_mosi <= cmd[31];
        tx_sr    <= cmd[30:0];
        rx_sr    <= '0;
      end else if (in_xfer && hp_done) begin
        edge_idx <= edge_idx + 1'b1;
      end
      if (sclk_rise) begin
        spi_sclk <= 1'b1;
        rx_sr    <= {rx_sr[14:0], spi_miso};
      end
      if (sclk_fall) begin
        spi_sclk <= 1'b0;
        spi_mosi <= tx_sr[30];
        tx_sr    <= {tx_sr[29:0], 1'b0};
      end
      if (xfer_done) spi_cs_n <= 1'b1;
      if (xfer_done && (state == S_CFG)) init_done <= 1'b1;
      data_valid <= xfer_done && (state == S_RD);
    end
  end

  // Bytes 3 and 4 of the read are the last 16 bits shifted in.
  assign samples[0] = rx_sr[15:8];
  assign samples[1] = rx_sr[7:0];

  for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
    accel_spi_axis u_axis (
      .clk    (clk),
      .reset  (reset),
      .load   (xfer_done && (state == S_RD)),
      .sample (samples[a]),
      .tilt   (tilts[a])
    );
  end

  assign accelX_OUT = tilts[0];
  assign accelY_OUT = tilts[1];
endmodule

// File: tb/tb_accel_spi_reader.sv
// Self-checking bench for accel_spi_reader with an SPI slave model and a transaction-level reference.
module tb_accel_spi_reader;
  localparam int HP     = 2;
  localparam int PERIOD = 50;

  logic       clk = 1'b0, reset = 1'b0, spi_miso = 1'b0;
  logic       spi_sclk, spi_mosi, spi_cs_n, data_valid, init_done;
  logic [8:0] accelX_OUT, accelY_OUT;
  int         checks = 0, errors = 0;

  accel_spi_reader #(.SIMULATE(1), .SIMULATE_FREQUENCY_CNT(PERIOD)) dut (
    .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n), .accelX_OUT(accelX_OUT), .accelY_OUT(accelY_OUT),
    .data_valid(data_valid), .init_done(init_done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sbyte(input logic [7:0] b);
    return int'($signed(b));
  endfunction

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h7F;
      2: return 8'h80;
      3: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  bit         rst_at_edge = 1'b0;
  always @(posedge clk) rst_at_edge <= reset;

  int         cyc = 0, rel = 0, ticks_since = 0, tx_idx = 0, nbits = 0, last_evt = 0, rise_cyc = 0;
  int         rd_done_total = 0, rd_idx = 0, cur_k = 0, exp_x = 256, exp_y = 256;
  bit         exp_init = 1'b0, exp_dv = 1'b0, in_tx = 1'b0, owed = 1'b0, mid_third = 1'b0;
  logic       prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  logic [31:0] mosi_cap = '0, resp = '0;
  logic [7:0] cur_x = '0, cur_y = '0;
`ifdef ACCEL_AVG_EN
  int         hx [4] = '{0, 0, 0, 0};
  int         hy [4] = '{0, 0, 0, 0};
  int         lit_avg [4] = '{288, 320, 352, 384};
`endif

  always @(negedge clk) begin
    cyc++;
    if (!rst_at_edge) begin
      chk("rst_cs_n", int'(spi_cs_n), 1);
      chk("rst_sclk", int'(spi_sclk), 0);
      chk("rst_mosi", int'(spi_mosi), 0);
      chk("rst_x", int'(accelX_OUT), 256);
      chk("rst_y", int'(accelY_OUT), 256);
      chk("rst_dv", int'(data_valid), 0);
      chk("rst_init", int'(init_done), 0);
      rel = 0; ticks_since = 0; tx_idx = 0; rd_idx = 0; in_tx = 0; owed = 0;
      exp_x = 256; exp_y = 256; exp_init = 0; spi_miso = 1'b0; rise_cyc = cyc;
`ifdef ACCEL_AVG_EN
      for (int i = 0; i < 4; i++) begin hx[i] = 0; hy[i] = 0; end
`endif
    end else begin
      rel++;
      if (rel % PERIOD == 0) ticks_since++;
      exp_dv = 1'b0;
      if (prev_cs && !spi_cs_n) begin
        if (tx_idx == 0) begin
          chk("powerup_delay", rel, 10);
          resp = $urandom;
        end else begin
          chk("gap_min", int'(cyc - rise_cyc >= 2 * HP), 1);
          chk("rd_has_tick", int'(ticks_since > 0), 1);
          if (owed) chk("tick_service", int'(cyc - rise_cyc <= 2 * HP + 3), 1);
          ticks_since = 0;
          cur_k = rd_idx; rd_idx++;
`ifdef ACCEL_AVG_EN
          cur_x = (cur_k < 4) ? 8'h40 : pick_byte();
          cur_y = pick_byte();
`else
          if (cur_k == 0)      begin cur_x = 8'h7F; cur_y = 8'h80; end
          else if (cur_k == 1) begin cur_x = 8'h40; cur_y = 8'hC0; end
          else begin cur_x = pick_byte(); cur_y = pick_byte(); end
`endif
          resp = {16'($urandom), cur_x, cur_y};
        end
        owed = 0; in_tx = 1; nbits = 0; mosi_cap = '0; last_evt = cyc;
        spi_miso = resp[31];
      end else if (in_tx && !prev_cs && spi_cs_n) begin
        chk("cs_tail", cyc - last_evt, HP);
        in_tx = 0; rise_cyc = cyc; owed = (ticks_since > 0);
        if (tx_idx == 0) begin
          chk("cfg_bits", nbits, 24);
          chk("cfg_bytes", int'(mosi_cap[23:0]), 32'h000A2D02);
          exp_init = 1'b1;
        end else begin
          chk("rd_bits", nbits, 32);
          chk("rd_bytes", int'(mosi_cap), 32'h0B080000);
`ifdef ACCEL_AVG_EN
          for (int i = 3; i > 0; i--) begin hx[i] = hx[i-1]; hy[i] = hy[i-1]; end
          hx[0] = sbyte(cur_x); hy[0] = sbyte(cur_y);
          exp_x = 256 + 2 * ((hx[0] + hx[1] + hx[2] + hx[3]) >>> 2);
          exp_y = 256 + 2 * ((hy[0] + hy[1] + hy[2] + hy[3]) >>> 2);
          if (cur_k < 4) chk("avg_ramp_x", int'(accelX_OUT), lit_avg[cur_k]);
`else
          exp_x = 256 + 2 * sbyte(cur_x);
          exp_y = 256 + 2 * sbyte(cur_y);
          if (cur_k == 0) begin
            chk("lit_x_7f", int'(accelX_OUT), 510);
            chk("lit_y_80", int'(accelY_OUT), 0);
          end else if (cur_k == 1) begin
            chk("lit_x_40", int'(accelX_OUT), 384);
            chk("lit_y_c0", int'(accelY_OUT), 128);
          end
`endif
          exp_dv = 1'b1;
          rd_done_total++;
        end
        tx_idx++;
      end else if (in_tx && (spi_sclk != prev_sclk)) begin
        chk("half_period", cyc - last_evt, HP);
        last_evt = cyc;
        if (spi_sclk) begin
          chk("mosi_setup", int'(spi_mosi), int'(prev_mosi));
          nbits++;
          mosi_cap = {mosi_cap[30:0], spi_mosi};
        end else begin
          resp = {resp[30:0], 1'b0};
          spi_miso = resp[31];
        end
      end else if (in_tx && spi_sclk && prev_sclk) begin
        chk("mosi_hold", int'(spi_mosi), int'(prev_mosi));
      end
      if (owed && spi_cs_n && (cyc - rise_cyc > 2 * HP + 3)) begin
        chk("tick_service_wait", cyc - rise_cyc, 2 * HP + 3);
        owed = 0;
      end
      chk("accelX", int'(accelX_OUT), exp_x);
      chk("accelY", int'(accelY_OUT), exp_y);
      chk("data_valid", int'(data_valid), int'(exp_dv));
      chk("init_done", int'(init_done), int'(exp_init));
      if (spi_cs_n) chk("sclk_idle", int'(spi_sclk), 0);
    end
    mid_third = in_tx && (tx_idx > 0) && (nbits >= 17) && (nbits <= 22);
    prev_cs = spi_cs_n; prev_sclk = spi_sclk; prev_mosi = spi_mosi;
  end

  initial begin
    int t;
    int base;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    t = 0;
    while (rd_done_total < 6 && t < 4000) begin @(posedge clk); t++; end
    if (rd_done_total < 6) chk("reads_before_abort", rd_done_total, 6);
    t = 0;
    while (!mid_third && t < 500) begin @(posedge clk); t++; end
    if (!mid_third) chk("reach_third_byte", int'(mid_third), 1);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    base = rd_done_total;
    t = 0;
    while (rd_done_total < base + 8 && t < 4000) begin @(posedge clk); t++; end
    if (rd_done_total < base + 8) chk("reads_after_abort", rd_done_total - base, 8);
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
